// File: rtl/coherent_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between two L1 caches and
// sends a registered invalidate to the opposite cache after each successful write.
module coherent_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_write_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic              req_valid_1,
    input  logic              req_write_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              ack_0,
    output logic              ack_1,
    output logic              resp_valid_0,
    output logic              resp_valid_1,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              inv_valid_0,
    output logic              inv_valid_1,
    output logic [ADDR_W-1:0] inv_addr_0,
    output logic [ADDR_W-1:0] inv_addr_1,
    output logic              mem_req_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a cache holds req_valid until its one-cycle ack; the grant
    // is taken only in IDLE, and requests seen in ISSUE/RESP are not queued.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // state is left as a plain named signal so checkers can bind to it.
    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic              grant_id, grant_id_n;
    logic [CNT_W-1:0]  count, count_n;

    logic              ack_0_n, ack_1_n;
    logic              resp_valid_0_n, resp_valid_1_n;
    logic [DATA_W-1:0] resp_rdata_n;
    logic              resp_err_n;
    logic              inv_valid_0_n, inv_valid_1_n;
    logic [ADDR_W-1:0] inv_addr_0_n, inv_addr_1_n;
    logic              mem_req_valid_n, mem_write_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;

    logic              finish;
    logic              fin_err;
    logic [DATA_W-1:0] fin_rdata;

    always_comb begin
        state_n         = state;
        last_grant_n    = last_grant;
        grant_id_n      = grant_id;
        count_n         = count;
        ack_0_n         = 1'b0;
        ack_1_n         = 1'b0;
        resp_valid_0_n  = 1'b0;
        resp_valid_1_n  = 1'b0;
        resp_rdata_n    = resp_rdata;
        resp_err_n      = resp_err;
        inv_valid_0_n   = 1'b0;
        inv_valid_1_n   = 1'b0;
        inv_addr_0_n    = inv_addr_0;
        inv_addr_1_n    = inv_addr_1;
        mem_req_valid_n = mem_req_valid;
        mem_write_n     = mem_write;
        mem_addr_n      = mem_addr;
        mem_wdata_n     = mem_wdata;
        finish          = 1'b0;
        fin_err         = 1'b0;
        fin_rdata       = '0;

        case (state)
            IDLE: begin
                if (req_valid_0 || req_valid_1) begin
                    // On contention the cache that did not win last time goes first.
                    if (req_valid_0 && req_valid_1)
                        grant_id_n = ~last_grant;
                    else
                        grant_id_n = req_valid_1;
                    if (grant_id_n) begin
                        ack_1_n     = 1'b1;
                        mem_write_n = req_write_1;
                        mem_addr_n  = req_addr_1;
                        mem_wdata_n = req_wdata_1;
                    end else begin
                        ack_0_n     = 1'b1;
                        mem_write_n = req_write_0;
                        mem_addr_n  = req_addr_0;
                        mem_wdata_n = req_wdata_0;
                    end
                    mem_req_valid_n = 1'b1;
                    count_n         = '0;
                    state_n         = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_done) begin
                    finish    = 1'b1;
                    fin_rdata = mem_rdata;
                end else if (count == CNT_LAST) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    count_n = count + 1'b1;
                end
                if (finish) begin
                    mem_req_valid_n = 1'b0;
                    resp_rdata_n    = fin_rdata;
                    resp_err_n      = fin_err;
                    if (grant_id) resp_valid_1_n = 1'b1;
                    else          resp_valid_0_n = 1'b1;
                    // Only a completed write makes the other cache's copy stale.
                    if (mem_write && !fin_err) begin
                        if (grant_id) begin
                            inv_valid_0_n = 1'b1;
                            inv_addr_0_n  = mem_addr;
                        end else begin
                            inv_valid_1_n = 1'b1;
                            inv_addr_1_n  = mem_addr;
                        end
                    end
                    state_n = RESP;
                end
            end
            RESP: begin
                last_grant_n = grant_id;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            count         <= '0;
            ack_0         <= 1'b0;
            ack_1         <= 1'b0;
            resp_valid_0  <= 1'b0;
            resp_valid_1  <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            inv_valid_0   <= 1'b0;
            inv_valid_1   <= 1'b0;
            inv_addr_0    <= '0;
            inv_addr_1    <= '0;
            mem_req_valid <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            state         <= state_n;
            last_grant    <= last_grant_n;
            grant_id      <= grant_id_n;
            count         <= count_n;
            ack_0         <= ack_0_n;
            ack_1         <= ack_1_n;
            resp_valid_0  <= resp_valid_0_n;
            resp_valid_1  <= resp_valid_1_n;
            resp_rdata    <= resp_rdata_n;
            resp_err      <= resp_err_n;
            inv_valid_0   <= inv_valid_0_n;
            inv_valid_1   <= inv_valid_1_n;
            inv_addr_0    <= inv_addr_0_n;
            inv_addr_1    <= inv_addr_1_n;
            mem_req_valid <= mem_req_valid_n;
            mem_write     <= mem_write_n;
            mem_addr      <= mem_addr_n;
            mem_wdata     <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Bench for coherent_mem_arbiter: directed test-plan steps, then randomized
// transactions checked against a transaction-level model of arbitration and responses.
module tb_coherent_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid_0 = 1'b0, req_write_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic [DW-1:0] req_wdata_0 = '0;
    logic          req_valid_1 = 1'b0, req_write_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic [DW-1:0] req_wdata_1 = '0;
    logic          ack_0, ack_1, resp_valid_0, resp_valid_1, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          inv_valid_0, inv_valid_1;
    logic [AW-1:0] inv_addr_0, inv_addr_1;
    logic          mem_req_valid, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    coherent_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid_0(req_valid_0), .req_write_0(req_write_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_write_1(req_write_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .ack_0(ack_0), .ack_1(ack_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .inv_valid_0(inv_valid_0), .inv_valid_1(inv_valid_1),
        .inv_addr_0(inv_addr_0), .inv_addr_1(inv_addr_1),
        .mem_req_valid(mem_req_valid), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    wire [1:0]         ack_v  = {ack_1, ack_0};
    wire [1:0]         resp_v = {resp_valid_1, resp_valid_0};
    wire [1:0]         inv_v  = {inv_valid_1, inv_valid_0};
    wire [1:0][AW-1:0] inv_a  = {inv_addr_1, inv_addr_0};

    // clock / reset block
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state: pending requests per cache and expected sticky outputs
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            p_valid [2];
    bit            p_write [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];
    int            last_won = 1;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_err   = 1'b0;
    logic [AW-1:0] exp_inv_addr [2];
    int            prev_ack = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int pick();
        if (p_valid[0] && p_valid[1]) return 1 - last_won;
        return p_valid[1] ? 1 : 0;
    endfunction

    // driver tasks
    task automatic drive_reqs();
        req_valid_0 = p_valid[0]; req_write_0 = p_write[0];
        req_addr_0  = p_addr[0];  req_wdata_0 = p_wdata[0];
        req_valid_1 = p_valid[1]; req_write_1 = p_write[1];
        req_addr_1  = p_addr[1];  req_wdata_1 = p_wdata[1];
    endtask

    task automatic set_req(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_valid[c] = 1'b1; p_write[c] = w; p_addr[c] = a; p_wdata[c] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ack"}, 32'(ack_v), 32'(0));
        check({tag, " resp_valid"}, 32'(resp_v), 32'(0));
        check({tag, " resp_rdata"}, 32'(resp_rdata), 32'(0));
        check({tag, " resp_err"}, 32'(resp_err), 32'(0));
        check({tag, " inv_valid"}, 32'(inv_v), 32'(0));
        check({tag, " inv_addr_0"}, 32'(inv_addr_0), 32'(0));
        check({tag, " inv_addr_1"}, 32'(inv_addr_1), 32'(0));
        check({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'(0));
        check({tag, " mem_write"}, 32'(mem_write), 32'(0));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(0));
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(0));
    endtask

    task automatic idle_cycle();
        drive_reqs();
        @(negedge clock);
        check("idle ack", 32'(ack_v), 32'(0));
        check("idle mem_req_valid", 32'(mem_req_valid), 32'(0));
        check("idle resp", 32'(resp_v), 32'(0));
    endtask

    // One full transaction: delay = ISSUE cycles before mem_done; >= TO means timeout.
    task automatic serve(input int delay, input logic [DW-1:0] rd, input bit chk_spacing);
        int            g, o, n_issue;
        bit            to, exp_inv;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        g = pick(); o = 1 - g;
        w = p_write[g]; a = p_addr[g]; wd = p_wdata[g];
        to = (delay >= TO);
        n_issue = to ? TO : delay + 1;
        drive_reqs();
        @(negedge clock);
        check("grant ack winner", 32'(ack_v[g]), 32'(1));
        check("grant ack other", 32'(ack_v[o]), 32'(0));
        check("grant mem_req_valid", 32'(mem_req_valid), 32'(1));
        check("grant mem_write", 32'(mem_write), 32'(w));
        check("grant mem_addr", 32'(mem_addr), 32'(a));
        check("grant mem_wdata", 32'(mem_wdata), 32'(wd));
        check("grant no resp", 32'(resp_v), 32'(0));
        if (chk_spacing) check("ack spacing", 32'(cyc - prev_ack), 32'(3));
        prev_ack = cyc;
        p_valid[g] = 1'b0;
        drive_reqs();
        for (int i = 0; i < n_issue; i++) begin
            mem_done  = (!to && i == n_issue - 1);
            mem_rdata = mem_done ? rd : DW'($urandom);
            @(negedge clock);
            mem_done = 1'b0;
            if (i < n_issue - 1) begin
                check("issue no resp", 32'(resp_v), 32'(0));
                check("issue mem_req_valid", 32'(mem_req_valid), 32'(1));
                check("issue mem_addr stable", 32'(mem_addr), 32'(a));
                check("issue no ack", 32'(ack_v), 32'(0));
            end
        end
        exp_rdata = to ? '0 : rd;
        exp_err   = to;
        exp_inv   = w && !to;
        if (exp_inv) exp_inv_addr[o] = a;
        check("resp winner", 32'(resp_v[g]), 32'(1));
        check("resp other", 32'(resp_v[o]), 32'(0));
        check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("inv to other", 32'(inv_v[o]), 32'(exp_inv));
        check("inv to winner", 32'(inv_v[g]), 32'(0));
        check("inv_addr other", 32'(inv_a[o]), 32'(exp_inv_addr[o]));
        check("resp mem_req_valid", 32'(mem_req_valid), 32'(0));
        last_won = g;
        @(negedge clock);
        check("post resp", 32'(resp_v), 32'(0));
        check("post inv", 32'(inv_v), 32'(0));
        check("post ack", 32'(ack_v), 32'(0));
        check("hold resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        check("hold resp_err", 32'(resp_err), 32'(exp_err));
        check("hold inv_addr_0", 32'(inv_addr_0), 32'(exp_inv_addr[0]));
        check("hold inv_addr_1", 32'(inv_addr_1), 32'(exp_inv_addr[1]));
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            p_valid[c] = 1'b0; p_write[c] = 1'b0; p_addr[c] = '0; p_wdata[c] = '0;
            exp_inv_addr[c] = '0;
        end
        drive_reqs();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        idle_cycle();

        // cache 0 read, immediate mem_done
        set_req(0, 1'b0, 16'h1234, 8'h00);
        serve(0, 8'hA5, 1'b0);

        // cache 1 write invalidates cache 0
        set_req(1, 1'b1, 16'h00F0, 8'h3C);
        serve(0, 8'h11, 1'b0);

        // both caches contend: grants alternate, acks 3 cycles apart
        set_req(0, 1'b0, 16'h0100, 8'h01);
        set_req(1, 1'b1, 16'h0200, 8'h02);
        serve(0, 8'h21, 1'b0);
        set_req(0, 1'b1, 16'h0300, 8'h03);
        serve(0, 8'h22, 1'b1);
        set_req(1, 1'b0, 16'h0400, 8'h04);
        serve(0, 8'h23, 1'b1);
        serve(0, 8'h24, 1'b1);

        // timeout write: error, no invalidate; then mem_done on the last ISSUE cycle
        set_req(0, 1'b1, 16'hCAFE, 8'h5A);
        serve(TO + 3, 8'h77, 1'b0);
        set_req(0, 1'b1, 16'hD00D, 8'h6B);
        serve(TO - 1, 8'h88, 1'b0);

        // reset during ISSUE of a cache 1 write
        set_req(1, 1'b1, 16'hBEEF, 8'h77);
        drive_reqs();
        @(negedge clock);
        check("rst-test ack_1", 32'(ack_1), 32'(1));
        p_valid[1] = 1'b0;
        drive_reqs();
        @(negedge clock);
        check("rst-test issuing", 32'(mem_req_valid), 32'(1));
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("mid reset");
        last_won = 1; exp_rdata = '0; exp_err = 1'b0;
        exp_inv_addr[0] = '0; exp_inv_addr[1] = '0;
        reset = 1'b1;
        idle_cycle();
        check("after reset inv", 32'(inv_v), 32'(0));
        set_req(0, 1'b0, 16'h0A0A, 8'h00);
        set_req(1, 1'b1, 16'h0B0B, 8'h99);
        serve(0, 8'h42, 1'b0);
        serve(1, 8'h43, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 2; c++)
                if (!p_valid[c] && $urandom_range(0, 1) == 1)
                    set_req(c, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if (!p_valid[0] && !p_valid[1]) begin
                idle_cycle();
            end else begin
                serve($urandom_range(0, TO + 1), DW'($urandom), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coherent_mem_arbiter.md
Name: coherent_mem_arbiter

Overview:
- Shares the single main-memory port between the two L1 cache controllers (cache 0, cache 1).
- Round-robin arbitration; one transaction in flight at a time.
- On each completed write, drives a registered invalidate pulse and address to the opposite cache, which clears that line's valid bit.
- Sits between the two cache miss/write-through interfaces and the memory controller.

Parameters:
ADDR_W, 16, address width (matches the 16-bit invalidate address)
DATA_W, 8, data width per transaction
TIMEOUT, 255, max consecutive ISSUE cycles without mem_done before an error response (must be >=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
req_valid_0  input  1  cache 0 request pending; held until ack_0
req_write_0  input  1  cache 0: 1=write, 0=read
req_addr_0  input  ADDR_W  cache 0 address
req_wdata_0  input  DATA_W  cache 0 write data
req_valid_1, req_write_1, req_addr_1, req_wdata_1  input  1/1/ADDR_W/DATA_W  same for cache 1
ack_0, ack_1  output  1  one-cycle pulse: request accepted
resp_valid_0, resp_valid_1  output  1  one-cycle pulse: transaction complete
resp_rdata  output  DATA_W  read data (valid with resp_valid_x)
resp_err  output  1  transaction timed out (valid with resp_valid_x)
inv_valid_0, inv_valid_1  output  1  one-cycle invalidate pulse to cache 0 / cache 1
inv_addr_0, inv_addr_1  output  ADDR_W  address to invalidate; holds its last value
mem_req_valid  output  1  memory request active
mem_write  output  1  memory command
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_done  input  1  memory completed the current request
mem_rdata  input  DATA_W  read data, valid when mem_done=1

Behaviour:
- All outputs are registered. Reset (reset=0 at a clock edge):
  - all outputs 0;
  - state=IDLE, last_grant=1 (cache 0 wins first), timeout counter=0.
- Reset mid-transaction abandons the transaction: no resp, no invalidate; mem_req_valid is 0 after that edge.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, grant one. Only one requesting → that one. Both requesting → the one not equal to last_grant.
  - Latch write/addr/wdata/id. Next cycle: ack_id=1, mem_req_valid=1 with latched fields, state=ISSUE, counter=0.
  - No request → stay in IDLE.
- ISSUE:
  - mem_req_valid and the mem_* fields are held stable.
  - mem_done=1 → capture mem_rdata, err=0, go to RESP.
  - Else counter+1; when counter reaches TIMEOUT → rdata=0, err=1, go to RESP.
  - mem_done in the same cycle as the timeout: mem_done wins (err=0).
- RESP (one cycle):
  - mem_req_valid=0; resp_valid_id=1; resp_rdata and resp_err driven.
  - If write and err=0: inv_valid of the other cache =1 and its inv_addr=latched addr.
  - last_grant=id; next state IDLE.
- Reads never invalidate. A timed-out write never invalidates.
- Timing:
  - Request sampled in IDLE at cycle T → ack and mem_req_valid at T+1.
  - mem_done at T+1 → resp at T+2; IDLE at T+3.
  - Minimum 3 cycles per transaction; a new grant is possible at T+3.
- Requester rules:
  - Deassert req_valid in the cycle after seeing ack.
  - Do not re-request before seeing resp_valid.
  - req_valid high during ISSUE/RESP is ignored, not queued.
- resp_rdata and resp_err hold their values outside the resp pulse.
- ack, resp_valid and inv_valid are never high for both caches in the same cycle.

Test Plan:
- Reset, then cache 0 read of 0x1234, with mem_done and rdata=0xA5 one cycle after mem_req_valid → ack_0 at T+1, resp_valid_0 at T+2 with rdata 0xA5, err=0, no inv pulse.
- Cache 1 write 0x00F0 data 0x3C → mem_write=1, mem_addr 0x00F0, mem_wdata 0x3C; with resp_valid_1: inv_valid_0=1, inv_addr_0=0x00F0; inv_valid_1 stays 0.
- Both caches request continuously, each re-requesting right after its resp → grants alternate 0,1,0,1; ack pulses spaced exactly 3 cycles apart with immediate mem_done.
- TIMEOUT=4, cache 0 write, mem_done never asserted → resp_valid_0 with err=1, rdata=0 after 4 ISSUE cycles; no invalidate. mem_done on the 4th ISSUE cycle → err=0 and invalidate issued.
- reset=0 asserted during ISSUE of a cache 1 write → next cycle all outputs 0, no resp/inv. After release, a cache 0 and cache 1 simultaneous request grants cache 0 first.
